// File: rtl/eusci_rx_ctrl_pkg.sv
// Shared definitions for the eUSCI UART receive controller:
// interrupt vector codes, the IFG bit layout and the receive flag FSM states.
package eusci_rx_ctrl_pkg;

  localparam logic [15:0] IV_RXIFG_C  = 16'h0002;
  localparam logic [15:0] IV_STTIFG_C = 16'h0006;

  // Bit positions inside UCAxIFG writes and the IV encoder source vector.
  localparam int IFG_RX_BIT  = 0;
  localparam int IFG_STT_BIT = 1;
  localparam int IFG_NUM     = 2;

  typedef enum logic {
    RX_EMPTY = 1'b0,
    RX_FULL  = 1'b1
  } rx_state_e;

  // In 7-bit mode the MSB of the received character is forced to zero.
  function automatic logic [7:0] rx_char(input logic [7:0] data, input logic seven_bit);
    return seven_bit ? {1'b0, data[6:0]} : data;
  endfunction

endpackage

// File: rtl/eusci_iv_encoder.sv
// Combinational interrupt vector priority encoder; source 0 has the highest priority.
// Also reports which source is currently encoded so an IV read can clear exactly that flag.
module eusci_iv_encoder #(
  parameter int          N     = 2,
  parameter logic [N*16-1:0] CODES = '0
) (
  input  logic [N-1:0]  pend_i,
  input  logic [N-1:0]  ie_i,
  output logic [15:0]   iv_o,
  output logic [N-1:0]  sel_o
);

  logic [N-1:0] active;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_active
      assign active[gi] = pend_i[gi] & ie_i[gi];
    end
  endgenerate

  // Walk from lowest to highest priority so the highest active source wins last.
  always_comb begin
    iv_o  = '0;
    sel_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (active[i]) begin
        iv_o     = CODES[i*16 +: 16];
        sel_o    = '0;
        sel_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eusci_rx_ctrl.sv
// eUSCI UART receive controller: owns UCAxRXBUF, RX/STT interrupt flags, sticky
// receive error flags and UCAxIV, and holds the receive state machine in reset.
module eusci_rx_ctrl
  import eusci_rx_ctrl_pkg::*;
#(
  parameter logic [15:0] IV_RXIFG  = IV_RXIFG_C,
  parameter logic [15:0] IV_STTIFG = IV_STTIFG_C
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic        wUCSWRST,
  input  logic        wUC7BIT,
  input  logic        wUCRXIE,
  input  logic        wUCSTTIE,
  input  logic        rSetRxIFG,
  input  logic [7:0]  RxData,
  input  logic        rUCPE,
  input  logic        rUCFE,
  input  logic        rUCOE,
  input  logic        oUCRXERR,
  input  logic        oSetSTTIFG,
  input  logic        RxBusy,
  input  logic        iRxBufRd,
  input  logic        iIVRd,
  input  logic        iIFGWr,
  input  logic [1:0]  iIFGData,
  output logic        oRxSMReset,
  output logic        RxIFG,
  output logic        STTIFG,
  output logic [7:0]  UCAxRXBUF,
  output logic        UCPE,
  output logic        UCFE,
  output logic        UCOE,
  output logic        UCRXERR,
  output logic        UCBUSY,
  output logic [15:0] UCAxIV,
  output logic        IRQ
);

  rx_state_e state_q, state_d;
  logic [7:0] rxbuf_q, rxbuf_d;
  logic       stt_q, stt_d;
  logic       pe_q, pe_d;
  logic       fe_q, fe_d;
  logic       oe_q, oe_d;
  logic       rxerr_q, rxerr_d;

  logic [IFG_NUM-1:0] iv_pend;
  logic [IFG_NUM-1:0] iv_ie;
  logic [IFG_NUM-1:0] iv_sel;
  logic [15:0]        iv_code;

  logic rx_wr_set;
  logic rx_clr;
  logic stt_clr;
  logic err_clr;

  assign iv_pend[IFG_RX_BIT]  = (state_q == RX_FULL);
  assign iv_pend[IFG_STT_BIT] = stt_q;
  assign iv_ie[IFG_RX_BIT]    = wUCRXIE;
  assign iv_ie[IFG_STT_BIT]   = wUCSTTIE;

  eusci_iv_encoder #(
    .N     (IFG_NUM),
    .CODES ({IV_STTIFG, IV_RXIFG})
  ) u_iv_encoder (
    .pend_i (iv_pend),
    .ie_i   (iv_ie),
    .iv_o   (iv_code),
    .sel_o  (iv_sel)
  );

  // Bus-side clear/write events; a hardware set in the same cycle always wins.
  assign rx_wr_set = iIFGWr & iIFGData[IFG_RX_BIT];
  assign rx_clr    = iRxBufRd | (iIVRd & iv_sel[IFG_RX_BIT]) | (iIFGWr & ~iIFGData[IFG_RX_BIT]);
  assign stt_clr   = (iIVRd & iv_sel[IFG_STT_BIT]) | (iIFGWr & ~iIFGData[IFG_STT_BIT]);
  assign err_clr   = iRxBufRd;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_EMPTY: if (rSetRxIFG || rx_wr_set) state_d = RX_FULL;
      RX_FULL:  if (!rSetRxIFG && !rx_wr_set && rx_clr) state_d = RX_EMPTY;
    endcase
    if (wUCSWRST) state_d = RX_EMPTY;
  end

  always_comb begin
    rxbuf_d = rxbuf_q;
    stt_d   = stt_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    oe_d    = oe_q;
    rxerr_d = rxerr_q;
    if (wUCSWRST) begin
      stt_d   = 1'b0;
      pe_d    = 1'b0;
      fe_d    = 1'b0;
      oe_d    = 1'b0;
      rxerr_d = 1'b0;
    end else begin
      if (rSetRxIFG) rxbuf_d = rx_char(RxData, wUC7BIT);
      // A buffer read wipes the old frame's errors before the new pulses latch.
      pe_d    = (pe_q    & ~err_clr) | rUCPE;
      fe_d    = (fe_q    & ~err_clr) | rUCFE;
      oe_d    = (oe_q    & ~err_clr) | rUCOE;
      rxerr_d = (rxerr_q & ~err_clr) | oUCRXERR;
      if (oSetSTTIFG) begin
        stt_d = 1'b1;
      end else if (iIFGWr) begin
        stt_d = iIFGData[IFG_STT_BIT];
      end else if (stt_clr) begin
        stt_d = 1'b0;
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (!reset) begin
      state_q <= RX_EMPTY;
      rxbuf_q <= '0;
      stt_q   <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      oe_q    <= 1'b0;
      rxerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rxbuf_q <= rxbuf_d;
      stt_q   <= stt_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      oe_q    <= oe_d;
      rxerr_q <= rxerr_d;
    end
  end

  assign oRxSMReset = ~reset | wUCSWRST;
  assign RxIFG      = (state_q == RX_FULL);
  assign STTIFG     = stt_q;
  assign UCAxRXBUF  = rxbuf_q;
  assign UCPE       = pe_q;
  assign UCFE       = fe_q;
  assign UCOE       = oe_q;
  assign UCRXERR    = rxerr_q;
  assign UCBUSY     = RxBusy & reset & ~wUCSWRST;
  assign UCAxIV     = iv_code;
  assign IRQ        = (iv_code != 16'h0000);

endmodule
